// File: rtl/sme_feeder.sv
// Host-side initiator for the SME string-match engine: buffers one string and one
// pattern from a byte-wide host port, streams them to SME, and reports the result.
module sme_feeder #(
    parameter int STR_DEPTH = 32,
    parameter int PAT_DEPTH = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic       ld_sel,
    input  logic [7:0] ld_char,
    input  logic       ld_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_status,
    output logic       busy
);

    localparam int SAW = $clog2(STR_DEPTH);
    localparam int PAW = $clog2(PAT_DEPTH);
    localparam int SLW = $clog2(STR_DEPTH + 1);
    localparam int PLW = $clog2(PAT_DEPTH + 1);
    localparam int CW  = $clog2(TIMEOUT + 1);

    localparam logic [SLW-1:0] STR_FULL = SLW'(STR_DEPTH);
    localparam logic [PLW-1:0] PAT_FULL = PLW'(PAT_DEPTH);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_NOSTR   = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_STR = 3'd1,
        SEND_PAT = 3'd2,
        WAIT     = 3'd3,
        REPORT   = 3'd4
    } state_t;

    state_t         state_r;
    logic [7:0]     str_mem_r [STR_DEPTH];
    logic [7:0]     pat_mem_r [PAT_DEPTH];
    logic [SLW-1:0] str_len_r;
    logic [PLW-1:0] pat_len_r;
    logic           str_restart_r;
    logic           pat_restart_r;
    logic           str_dirty_r;
    logic [SLW-1:0] str_rd_r;
    logic [PLW-1:0] pat_rd_r;
    logic [CW-1:0]  cnt_r;
    logic           cap_match_r;
    logic [4:0]     cap_index_r;
    logic [1:0]     cap_status_r;

    logic           ld_fire_s;
    logic [SLW-1:0] str_wr_idx_s;
    logic [PLW-1:0] pat_wr_idx_s;
    logic           str_room_s;
    logic           pat_room_s;
    logic [SLW-1:0] str_len_nxt_s;
    logic [PLW-1:0] pat_len_nxt_s;

    // Load-side write position and saturating length; a write after ld_last restarts at 0.
    always_comb begin
        ld_fire_s = ld_valid & ld_ready;
        if (str_restart_r) begin
            str_wr_idx_s = '0;
        end else begin
            str_wr_idx_s = str_len_r;
        end
        if (pat_restart_r) begin
            pat_wr_idx_s = '0;
        end else begin
            pat_wr_idx_s = pat_len_r;
        end
        str_room_s = (str_wr_idx_s < STR_FULL);
        pat_room_s = (pat_wr_idx_s < PAT_FULL);
        if (str_room_s) begin
            str_len_nxt_s = str_wr_idx_s + SLW'(1);
        end else begin
            str_len_nxt_s = STR_FULL;
        end
        if (pat_room_s) begin
            pat_len_nxt_s = pat_wr_idx_s + PLW'(1);
        end else begin
            pat_len_nxt_s = PAT_FULL;
        end
    end

    // Character storage; overflow characters are accepted but not stored.
    always_ff @(posedge clk) begin
        if (!reset && ld_fire_s && !ld_sel && str_room_s) begin
            str_mem_r[str_wr_idx_s[SAW-1:0]] <= ld_char;
        end
        if (!reset && ld_fire_s && ld_sel && pat_room_s) begin
            pat_mem_r[pat_wr_idx_s[PAW-1:0]] <= ld_char;
        end
    end

    // Control FSM with all host- and SME-facing outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            str_len_r     <= '0;
            pat_len_r     <= '0;
            str_restart_r <= 1'b0;
            pat_restart_r <= 1'b0;
            str_dirty_r   <= 1'b0;
            str_rd_r      <= '0;
            pat_rd_r      <= '0;
            cnt_r         <= '0;
            cap_match_r   <= 1'b0;
            cap_index_r   <= 5'd0;
            cap_status_r  <= 2'd0;
            ld_ready      <= 1'b1;
            busy          <= 1'b0;
            chardata      <= 8'd0;
            isstring      <= 1'b0;
            ispattern     <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= 5'd0;
            res_status    <= 2'd0;
        end else begin
            res_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    chardata  <= 8'd0;
                    isstring  <= 1'b0;
                    ispattern <= 1'b0;
                    if (ld_fire_s && !ld_sel) begin
                        str_len_r     <= str_len_nxt_s;
                        str_restart_r <= ld_last;
                        if (ld_last) begin
                            str_dirty_r <= 1'b1;
                        end
                    end else if (ld_fire_s && ld_sel) begin
                        pat_len_r     <= pat_len_nxt_s;
                        pat_restart_r <= ld_last;
                        if (ld_last) begin
                            str_rd_r <= '0;
                            pat_rd_r <= '0;
                            ld_ready <= 1'b0;
                            busy     <= 1'b1;
                            if (str_len_r == '0) begin
                                cap_match_r  <= 1'b0;
                                cap_index_r  <= 5'd0;
                                cap_status_r <= ST_NOSTR;
                                state_r      <= REPORT;
                            end else if (str_dirty_r) begin
                                state_r <= SEND_STR;
                            end else begin
                                state_r <= SEND_PAT;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND_STR: begin
                    chardata  <= str_mem_r[str_rd_r[SAW-1:0]];
                    isstring  <= 1'b1;
                    ispattern <= 1'b0;
                    // Last string character hands straight over to the pattern, no idle cycle.
                    if (str_rd_r == str_len_r - SLW'(1)) begin
                        str_dirty_r <= 1'b0;
                        state_r     <= SEND_PAT;
                    end else begin
                        str_rd_r <= str_rd_r + SLW'(1);
                    end
                end
                SEND_PAT: begin
                    chardata  <= pat_mem_r[pat_rd_r[PAW-1:0]];
                    isstring  <= 1'b0;
                    ispattern <= 1'b1;
                    if (pat_rd_r == pat_len_r - PLW'(1)) begin
                        cnt_r   <= '0;
                        state_r <= WAIT;
                    end else begin
                        pat_rd_r <= pat_rd_r + PLW'(1);
                    end
                end
                WAIT: begin
                    chardata  <= 8'd0;
                    isstring  <= 1'b0;
                    ispattern <= 1'b0;
                    // A result arriving on the timeout edge still counts as a result.
                    if (valid) begin
                        cap_match_r  <= match;
                        cap_index_r  <= match_index;
                        cap_status_r <= ST_OK;
                        state_r      <= REPORT;
                    end else if (cnt_r == TO_LAST) begin
                        cap_match_r  <= 1'b0;
                        cap_index_r  <= 5'd0;
                        cap_status_r <= ST_TIMEOUT;
                        state_r      <= REPORT;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                REPORT: begin
                    chardata   <= 8'd0;
                    isstring   <= 1'b0;
                    ispattern  <= 1'b0;
                    res_valid  <= 1'b1;
                    res_match  <= cap_match_r;
                    res_index  <= cap_index_r;
                    res_status <= cap_status_r;
                    ld_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    chardata  <= 8'd0;
                    isstring  <= 1'b0;
                    ispattern <= 1'b0;
                    ld_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: scoreboard queues for the SME character stream and
// host results, plus a small SME responder model.
module tb_sme_feeder;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, ld_valid, ld_sel, ld_last;
    logic [7:0] ld_char;
    logic       ld_ready, isstring, ispattern, res_valid, res_match, busy;
    logic [7:0] chardata;
    logic       valid, match;
    logic [4:0] match_index, res_index;
    logic [1:0] res_status;

    int checks = 0;
    int errors = 0;
    int res_seen = 0;
    int str_cycles = 0;

    logic [9:0] exp_chars [$];
    logic [7:0] exp_res [$];

    bit         sme_en = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_index = 5'd0;
    logic       idle_match = 1'b0;
    logic [4:0] idle_index = 5'd0;

    always #5 clk = ~clk;

    sme_feeder #(.STR_DEPTH(32), .PAT_DEPTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_char(ld_char), .ld_last(ld_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_status(res_status), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {ld_ready, busy, res_valid, res_match, res_index, res_status,
                isstring, ispattern, chardata};
    endfunction

    task automatic push_text(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_chars.push_back({~sel, sel, 8'(s[i])});
        end
    endtask

    task automatic load_char(input logic sel, input logic [7:0] ch, input logic last);
        @(negedge clk);
        check("ld_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_char  = ch;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_text(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            load_char(sel, 8'(s[i]), i == s.len() - 1);
        end
    endtask

    task automatic wait_res(input int target);
        for (int c = 0; c < 200; c++) begin
            if (res_seen >= target) break;
            @(negedge clk);
        end
        check("result_arrived", res_seen >= target, 1);
    endtask

    // SME responder: result arrives 3 cycles after the pattern stream ends.
    initial begin : sme_model
        int cd;
        bit prev_pat;
        cd = 0;
        prev_pat = 1'b0;
        valid = 1'b0;
        match = 1'b0;
        match_index = 5'd0;
        forever begin
            @(negedge clk);
            valid = 1'b0;
            match = idle_match;
            match_index = idle_index;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    valid = 1'b1;
                    match = sme_match;
                    match_index = sme_index;
                end
            end
            if (sme_en && prev_pat && !ispattern) cd = 3;
            prev_pat = ispattern;
        end
    end

    // Output monitor: pops the scoreboards whenever the DUT produces traffic.
    initial begin : monitor
        bit prev_stream;
        logic [9:0] e;
        logic [7:0] r;
        prev_stream = 1'b0;
        forever begin
            @(negedge clk);
            if (isstring || ispattern) begin
                if (isstring) str_cycles++;
                check("stream_busy", {busy, ld_ready}, 2'b10);
                if (exp_chars.size() == 0) begin
                    check("unexpected_char", {isstring, ispattern, chardata}, 10'h0);
                end else begin
                    e = exp_chars.pop_front();
                    check("char", {isstring, ispattern, chardata}, e);
                end
            end else if (prev_stream) begin
                check("stream_gap", exp_chars.size(), 0);
            end
            prev_stream = isstring || ispattern;
            if (res_valid) begin
                res_seen++;
                if (exp_res.size() == 0) begin
                    check("unexpected_result", {res_match, res_index, res_status}, 8'hff);
                end else begin
                    r = exp_res.pop_front();
                    check("result", {res_match, res_index, res_status}, r);
                end
            end
        end
    end

    initial begin : main
        int n, k;
        bit seen_pat, started;
        reset = 1'b1;
        ld_valid = 1'b0;
        ld_sel = 1'b0;
        ld_char = 8'd0;
        ld_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", outs(), {1'b1, 20'h0});
        reset = 1'b0;

        // Job 1: "ABCDE" / "CD", match at index 2.
        sme_en = 1'b1; sme_match = 1'b1; sme_index = 5'd2;
        push_text(1'b0, "ABCDE");
        push_text(1'b1, "CD");
        exp_res.push_back({1'b1, 5'd2, 2'd0});
        load_text(1'b0, "ABCDE");
        load_text(1'b1, "CD");
        @(negedge clk);
        check("latency_pre", {isstring, busy, ld_ready}, 3'b010);
        @(negedge clk);
        check("latency_first", {isstring, chardata}, {1'b1, 8'h41});
        wait_res(1);

        // Job 2: stored string reused, pattern "XY", no match.
        sme_match = 1'b0; sme_index = 5'd0;
        push_text(1'b1, "XY");
        exp_res.push_back({1'b0, 5'd0, 2'd0});
        load_text(1'b1, "XY");
        wait_res(2);

        // Job 3: SME silent, timeout after 16 WAIT cycles.
        sme_en = 1'b0; idle_match = 1'b1; idle_index = 5'd31;
        push_text(1'b1, "Q");
        exp_res.push_back({1'b0, 5'd0, 2'd1});
        load_text(1'b1, "Q");
        n = 0; seen_pat = 1'b0; started = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (started) begin
                n++;
                if (res_valid) break;
            end else if (seen_pat && !ispattern) begin
                started = 1'b1;
            end
            if (ispattern) seen_pat = 1'b1;
        end
        check("timeout_cycles", n, TO);
        wait_res(3);
        idle_match = 1'b0; idle_index = 5'd0;

        // Job 4: reset, then pattern with no string -> status 2.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_again", outs(), {1'b1, 20'h0});
        reset = 1'b0;
        exp_res.push_back({1'b0, 5'd0, 2'd2});
        load_text(1'b1, "Z");
        @(negedge clk);
        check("nostr_gap", {res_valid, busy}, 2'b01);
        @(negedge clk);
        check("nostr_pulse", res_valid, 1);
        wait_res(4);

        // Job 5: 40-char string, only 32 kept.
        str_cycles = 0;
        sme_en = 1'b1; sme_match = 1'b1; sme_index = 5'd5;
        for (int i = 0; i < 32; i++) exp_chars.push_back({2'b10, 8'(8'h30 + i)});
        push_text(1'b1, "AB");
        exp_res.push_back({1'b1, 5'd5, 2'd0});
        for (int i = 0; i < 40; i++) load_char(1'b0, 8'(8'h30 + i), i == 39);
        load_text(1'b1, "AB");
        wait_res(5);
        check("str_cycles", str_cycles, 32);

        // Job 6: reset on the third string character, then pattern-only -> status 2.
        push_text(1'b0, "ABCDE");
        push_text(1'b1, "C");
        load_text(1'b0, "ABCDE");
        load_text(1'b1, "C");
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (isstring) k++;
            if (k == 3) break;
        end
        check("mid_reached", k, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_chars.delete();
        @(negedge clk);
        check("mid_reset_state", outs(), {1'b1, 20'h0});
        reset = 1'b0;
        exp_res.push_back({1'b0, 5'd0, 2'd2});
        load_text(1'b1, "K");
        wait_res(6);

        repeat (10) @(negedge clk);
        check("chars_left", exp_chars.size(), 0);
        check("results_left", exp_res.size(), 0);
        check("result_count", res_seen, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
Host-side initiator for the SME string-match engine. It buffers one target string and one pattern loaded by a host over a byte-wide valid/ready port. It streams them to SME with isstring/ispattern framing, one character per cycle, then waits for SME valid. The captured match/match_index is returned to the host with a status code; this block is the driver that feeds SME in the integrated design.

Parameters:
STR_DEPTH, 32, string buffer depth in characters (match_index is 5 bits)
PAT_DEPTH, 8, pattern buffer depth in characters
TIMEOUT, 1023, max cycles in WAIT before abort (counter 10 bits)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ld_valid  input  1  host character valid
ld_ready  output  1  feeder accepts character
ld_sel  input  1  0 = string buffer, 1 = pattern buffer
ld_char  input  8  character byte
ld_last  input  1  last character of current string/pattern
chardata  output  8  character to SME
isstring  output  1  chardata is a string character
ispattern  output  1  chardata is a pattern character
valid  input  1  SME result valid
match  input  1  SME match flag
match_index  input  5  SME match position
res_valid  output  1  one-cycle result pulse
res_match  output  1  captured match
res_index  output  5  captured match_index
res_status  output  2  0 ok, 1 timeout, 2 no string loaded
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0 except ld_ready=1. FSM returns to IDLE. str_len=pat_len=0, str_dirty=0. Reset wins over any other event, including mid-stream; buffered string is discarded.
- States: IDLE, SEND_STR, SEND_PAT, WAIT, REPORT. All outputs registered.
- IDLE: ld_ready=1; a handshake is ld_valid & ld_ready.
- First character after a previous ld_last (per buffer) restarts that buffer's write index at 0.
- Characters beyond depth are accepted and dropped; length saturates at STR_DEPTH/PAT_DEPTH.
- String ld_last sets str_dirty=1 and stays in IDLE.
- Pattern ld_last: if str_len==0 go REPORT with status 2, match 0, index 0. Else go SEND_STR if str_dirty, otherwise SEND_PAT.
- SEND_STR: on cycles 1..str_len after entry, chardata=str[i] and isstring=1. After the last character, str_dirty clears and the FSM enters SEND_PAT, whose first character follows on the next cycle with no gap.
- SEND_PAT: chardata=pat[i], ispattern=1 for pat_len cycles, then WAIT.
- WAIT: isstring=ispattern=0, chardata=0. Counter starts at 0 and increments each cycle.
  - valid sampled 1: capture match/match_index, go REPORT with status 0.
  - Counter reaches TIMEOUT: go REPORT with status 1, res_match=0, res_index=0.
  - valid and TIMEOUT on the same edge: valid wins.
- valid while not in WAIT is ignored.
- REPORT: res_valid=1 for exactly one cycle, with res_match/res_index/res_status stable; these hold until the next REPORT. Then IDLE.
- ld_ready=0 and busy=1 in every state other than IDLE.
- Subsequent patterns reuse the stored string without resending it (str_dirty=0), matching SME multi-pattern-per-string semantics.
- Latency: pattern ld_last accepted at edge k → first isstring char visible after edge k+1. Full job = str_len + pat_len + SME latency + 2 cycles.

Test Plan:
- Load string "ABCDE", pattern "CD"; SME model asserts valid 3 cycles after pattern → isstring high 5 cycles (41..45h), ispattern 2 cycles (43h,44h) back-to-back; res_valid pulse, match=1, index=2, status 0.
- Second pattern "XY" with no string reload → no isstring cycles; ispattern 2 cycles; model match=0 → res_match=0, status 0.
- TIMEOUT=16, model never asserts valid → res_valid exactly 16 cycles after entering WAIT; status 1, match 0, index 0.
- Pattern loaded after reset with no string → no SME traffic; res_valid next-next cycle, status 2.
- 40-char string, STR_DEPTH=32 → all 40 accepted (ld_ready stays 1); exactly 32 isstring cycles sent.
- Reset asserted mid SEND_STR (cycle 3 of 5) → next edge all outputs 0, ld_ready=1. Subsequent pattern-only load → status 2.
